// File: rtl/ram_burst_read_ctrl_if.sv
// RAM burst read port plus the valid/ready burst stream toward the consumer.
// The controller drives the master side; RAM model and consumer form the slave side.
interface ram_burst_read_ctrl_if #(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4,
   parameter int DEPTH     = 1024
);
   localparam int DEPTH_BITS = $clog2(DEPTH);
   localparam int DATA_W     = BURST_LEN * WIDTH;

   logic                  ram_read_en;
   logic [DEPTH_BITS-1:0] ram_read_address;
   logic [DATA_W-1:0]     ram_read_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_W-1:0]     m_data;
   logic                  m_last;

   modport master (
      output ram_read_en, ram_read_address, m_valid, m_data, m_last,
      input  ram_read_data, m_ready
   );

   modport slave (
      input  ram_read_en, ram_read_address, m_valid, m_data, m_last,
      output ram_read_data, m_ready
   );
endinterface

// File: rtl/ram_burst_read_ctrl.sv
// Burst read controller: streams num_bursts RAM bursts starting at base_addr
// through a credit-limited output FIFO to a valid/ready consumer.
module ram_burst_read_ctrl #(
   parameter int  WIDTH      = 8,
   parameter int  BURST_LEN  = 4,
   parameter int  DEPTH      = 1024,
   parameter int  FIFO_DEPTH = 4,
   localparam int DEPTH_BITS = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DEPTH_BITS-1:0] base_addr,
   input  logic [DEPTH_BITS-1:0] num_bursts,
   output logic                  busy,
   output logic                  done,
   ram_burst_read_ctrl_if.master bus
);
   localparam int DATA_W = BURST_LEN * WIDTH;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int CRED_W = PTR_W + 3;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t                state_q, state_d;
   logic [DEPTH_BITS-1:0] num_q, num_d, issued_q, issued_d, pushed_q, pushed_d;
   logic [DEPTH_BITS-1:0] addr_q, addr_d, next_addr_q, next_addr_d;
   logic                  rd_en_q, rd_en_d, stage1_q, stage1_d, stage2_q, stage2_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [DATA_W:0]       fifo_q [FIFO_DEPTH];
   logic [DATA_W:0]       fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  issue_s, push_s, pop_s, push_last_s, m_valid_s;
   logic [CRED_W-1:0]     outstanding_s;

   function automatic logic [DEPTH_BITS-1:0] next_burst_addr(input logic [DEPTH_BITS-1:0] a);
      logic [DEPTH_BITS:0] sum;
      sum = {1'b0, a} + (DEPTH_BITS+1)'(BURST_LEN);
      if (sum >= (DEPTH_BITS+1)'(DEPTH)) begin
         sum = sum - (DEPTH_BITS+1)'(DEPTH);
      end
      return sum[DEPTH_BITS-1:0];
   endfunction

   assign m_valid_s   = (count_q != '0);
   assign pop_s       = m_valid_s & bus.m_ready;
   assign push_s      = stage2_q;
   assign push_last_s = (pushed_q == (num_q - DEPTH_BITS'(1)));
   // Every issued read already owns a FIFO slot; a pop this cycle frees one early.
   assign outstanding_s = CRED_W'(count_q) + CRED_W'(rd_en_q) + CRED_W'(stage1_q)
                        + CRED_W'(stage2_q) - CRED_W'(pop_s);

   // Job sequencing: latch the job, pace read issue on FIFO credit, close out.
   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      issued_d    = issued_q;
      addr_d      = addr_q;
      next_addr_d = next_addr_q;
      issue_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_bursts != '0) begin
                  state_d     = RUN;
                  num_d       = num_bursts;
                  issue_s     = 1'b1;
                  issued_d    = DEPTH_BITS'(1);
                  addr_d      = base_addr;
                  next_addr_d = next_burst_addr(base_addr);
               end else begin
                  state_d = DONE;
                  num_d   = '0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (issued_q == num_q) begin
               state_d = DRAIN;
            end else if (outstanding_s < CRED_W'(FIFO_DEPTH)) begin
               issue_s     = 1'b1;
               issued_d    = issued_q + DEPTH_BITS'(1);
               addr_d      = next_addr_q;
               next_addr_d = next_burst_addr(next_addr_q);
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (!rd_en_q && !stage1_q && !stage2_q && (count_q == '0)) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rd_en_d  = issue_s;
      stage1_d = rd_en_q;
      stage2_d = stage1_q;
      busy_d   = (state_d != IDLE);
      done_d   = (state_q == DONE);
   end

   // Output FIFO bookkeeping; each entry carries its burst plus the job-final flag.
   always_comb begin
      fifo_d = fifo_q;
      if (push_s) begin
         fifo_d[wr_ptr_q] = {push_last_s, bus.ram_read_data};
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (state_q == IDLE) begin
         pushed_d = '0;
      end else if (push_s) begin
         pushed_d = pushed_q + DEPTH_BITS'(1);
      end else begin
         pushed_d = pushed_q;
      end
   end

   // Control and pipeline registers; reset drops any reads still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         num_q       <= '0;
         issued_q    <= '0;
         pushed_q    <= '0;
         addr_q      <= '0;
         next_addr_q <= '0;
         rd_en_q     <= 1'b0;
         stage1_q    <= 1'b0;
         stage2_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         issued_q    <= issued_d;
         pushed_q    <= pushed_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         rd_en_q     <= rd_en_d;
         stage1_q    <= stage1_d;
         stage2_q    <= stage2_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage; contents are only observed through the count, so no reset.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign busy                 = busy_q;
   assign done                 = done_q;
   assign bus.ram_read_en      = rd_en_q;
   assign bus.ram_read_address = addr_q;
   assign bus.m_valid          = m_valid_s;
   assign bus.m_data           = fifo_q[rd_ptr_q][DATA_W-1:0];
   assign bus.m_last           = m_valid_s & fifo_q[rd_ptr_q][DATA_W];
endmodule

// File: doc/ram_burst_read_ctrl.md
RAM_BURST_READ_CTRL -- requirements
Module: ram_burst_read_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per RAM word.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning words returned per RAM burst read.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning RAM words; DEPTH_BITS = clog2(DEPTH).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (bursts), power of 2, >= 3.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic samples on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning begin a job; sampled only in IDLE.
REQ-008 SHALL have port base_addr, input, DEPTH_BITS, meaning first word address of the job.
REQ-009 SHALL have port num_bursts, input, DEPTH_BITS, meaning bursts in the job.
REQ-010 SHALL have port busy, output, 1, meaning a job is active (state != IDLE).
REQ-011 SHALL have port done, output, 1, meaning one-cycle pulse at job completion.
REQ-012 SHALL have port ram_read_en, output, 1, meaning read strobe to the RAM_BURST read port.
REQ-013 SHALL have port ram_read_address, output, DEPTH_BITS, meaning burst start address.
REQ-014 SHALL have port ram_read_data, input, BURST_LEN*WIDTH, meaning RAM burst data, valid 2 cycles after ram_read_en.
REQ-015 SHALL have port m_valid, output, 1, meaning m_data holds a burst.
REQ-016 SHALL have port m_ready, input, 1, meaning consumer accepts; transfer when m_valid and m_ready.
REQ-017 SHALL have port m_data, output, BURST_LEN*WIDTH, meaning burst word, bit order unchanged from ram_read_data.
REQ-018 SHALL have port m_last, output, 1, meaning asserted with m_valid on the job's final burst.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 and num_bursts!=0 -> latch base_addr/num_bursts, go RUN next cycle; start=1 and num_bursts=0 -> DONE, no RAM read issued.
REQ-021 RUN: issue one ram_read_en per cycle while issued < num_bursts and (fifo_count + inflight) < FIFO_DEPTH (credit rule; never overflow).
REQ-022 Read address SHALL be base_addr + k*BURST_LEN for burst k, modulo DEPTH (wrap from DEPTH-BURST_LEN to 0).
REQ-023 ram_read_address SHALL be held at last value when ram_read_en=0.
REQ-024 A 2-stage valid pipeline SHALL track in-flight reads; ram_read_data SHALL be written to the FIFO on the cycle the stage-2 flag is set.
REQ-025 RUN -> DRAIN on the cycle the last read issues; DRAIN -> DONE when inflight=0, fifo empty and final burst transferred.
REQ-026 DONE: done=1 exactly one cycle, then IDLE; busy=0 in that IDLE cycle.
REQ-027 m_valid SHALL equal fifo non-empty; m_data from FIFO head register (no combinational path from ram_read_data).
REQ-028 Simultaneous FIFO push and pop SHALL keep count unchanged; pop with empty FIFO impossible by construction.
REQ-029 m_last SHALL be 1 only for the burst with index num_bursts-1.
REQ-030 start while busy SHALL be ignored; latched job parameters SHALL not change mid-job.
REQ-031 Minimum latency: start at cycle 0 -> ram_read_en cycle 1 -> m_valid cycle 4 (1 read + 2 RAM + FIFO write).
REQ-032 With m_ready held 1, throughput SHALL be one burst per cycle after fill.

Reset
REQ-033 reset=1 SHALL force state IDLE, busy=0, done=0, ram_read_en=0, ram_read_address=0, m_valid=0, m_last=0, FIFO count 0, inflight 0.
REQ-034 Reset mid-job SHALL abort it; RAM data arriving after reset SHALL be discarded, no done pulse.
REQ-035 reset SHALL take priority over start in the same cycle.

Verification
REQ-036 RAM preloaded mem[i]=i%256; start, base=0, num=4, m_ready=1 -> reads at 0,4,8,12 on consecutive cycles; 4 bursts matching RAM words 0-15; m_last on 4th; one done pulse.
REQ-037 base=1016, num=4 -> addresses 1016,1020,0,4; data matches wrapped words.
REQ-038 num=16, m_ready=0 for 20 cycles then 1 -> at most FIFO_DEPTH outstanding reads, ram_read_en stalls, all 16 bursts delivered in order, none lost/duplicated.
REQ-039 num=0 -> no ram_read_en, done pulses 2 cycles after start, m_valid stays 0.
REQ-040 reset asserted 3 cycles into num=8 job -> all outputs at reset values next cycle; following job base=100, num=1 returns only words 100-103.
REQ-041 start pulsed again during busy job -> ignored; exactly one done pulse.
